// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared field widths, address slicing and FSM state encoding
//               for the direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W  = 8;
    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int BLOCK_W = 32;
    localparam int MADDR_W = TAG_W + IDX_W;

    // CPU byte address layout: tag[7:5], index[4:2], offset[1:0]
    localparam int OFF_LSB = 0;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_UPDATE    = 2'd3
    } cache_state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Miss-handling FSM for dcache. Sequences the optional victim
//               write-back and the block fetch, drives registered memory
//               strobes/address/data, and hands the fetched block back to the
//               line arrays for one UPDATE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 access_valid,
    input  logic                 hit,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic [TAG_W-1:0]     victim_tag,
    input  logic [BLOCK_W-1:0]   victim_data,
    input  logic [TAG_W-1:0]     cpu_tag,
    input  logic [IDX_W-1:0]     cpu_idx,
    input  logic                 mem_busywait,
    input  logic [BLOCK_W-1:0]   mem_readdata,
    output logic                 busy,
    output logic                 fill_en,
    output logic [IDX_W-1:0]     fill_idx,
    output logic [TAG_W-1:0]     fill_tag,
    output logic [BLOCK_W-1:0]   fill_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [MADDR_W-1:0]   mem_address,
    output logic [BLOCK_W-1:0]   mem_writedata
);

    cache_state_t         r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [TAG_W-1:0]     r_tag;
    logic [BLOCK_W-1:0]   r_block;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [MADDR_W-1:0]   r_mem_address;
    logic [BLOCK_W-1:0]   r_mem_writedata;

    // Miss FSM; index and tag are latched at miss start so the fill
    // completes even if the CPU drops or changes its request mid-miss.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_tag           <= '0;
            r_block         <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (access_valid && !hit) begin
                        r_idx <= cpu_idx;
                        r_tag <= cpu_tag;
                        if (victim_valid && victim_dirty) begin
                            r_state         <= ST_WRITEBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {victim_tag, cpu_idx};
                            r_mem_writedata <= victim_data;
                        end else begin
                            r_state       <= ST_FETCH;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {cpu_tag, cpu_idx};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!mem_busywait) begin
                        r_state         <= ST_FETCH;
                        r_mem_write     <= 1'b0;
                        r_mem_writedata <= '0;
                        r_mem_read      <= 1'b1;
                        r_mem_address   <= {r_tag, r_idx};
                    end
                end
                ST_FETCH: begin
                    if (!mem_busywait) begin
                        r_state       <= ST_UPDATE;
                        r_mem_read    <= 1'b0;
                        r_mem_address <= '0;
                        r_block       <= mem_readdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign fill_en       = (r_state == ST_UPDATE);
    assign fill_idx      = r_idx;
    assign fill_tag      = r_tag;
    assign fill_data     = r_block;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module      : dcache
// Description : Direct-mapped, write-back, write-allocate byte data cache.
//               Holds the tag/valid/dirty/data arrays and the hit path;
//               misses are sequenced by dcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache
    import cache_pkg::*;
#(
    parameter int NSETS       = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [ADDR_W-1:0]    cpu_address,
    input  logic [7:0]           cpu_writedata,
    output logic [7:0]           cpu_readdata,
    output logic                 cpu_busywait,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [MADDR_W-1:0]   mem_address,
    output logic [BLOCK_W-1:0]   mem_writedata,
    input  logic [BLOCK_W-1:0]   mem_readdata,
    input  logic                 mem_busywait
);

    logic [NSETS-1:0]           r_valid;
    logic [NSETS-1:0]           r_dirty;
    logic [TAG_W-1:0]           r_tags [NSETS];
    logic [BLOCK_BYTES*8-1:0]   r_data [NSETS];

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [OFF_W-1:0]     w_off;
    logic                 w_access_valid;
    logic                 w_hit;
    logic [BLOCK_W-1:0]   w_line;
    logic [7:0]           w_byte;
    logic                 w_busy;
    logic                 w_write_hit;
    logic                 w_read_hit;
    logic                 w_fill_en;
    logic [IDX_W-1:0]     w_fill_idx;
    logic [TAG_W-1:0]     w_fill_tag;
    logic [BLOCK_W-1:0]   w_fill_data;

    assign w_tag          = cpu_address[TAG_LSB +: TAG_W];
    assign w_idx          = cpu_address[IDX_LSB +: IDX_W];
    assign w_off          = cpu_address[OFF_LSB +: OFF_W];
    // Both strobes high is not an access at all
    assign w_access_valid = cpu_read ^ cpu_write;
    assign w_hit          = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_line         = r_data[w_idx];
    assign w_byte         = w_line[{w_off, 3'b000} +: 8];

    // Hits are only serviced while the miss FSM is idle
    assign w_write_hit    = !w_busy && cpu_write && !cpu_read && w_hit;
    assign w_read_hit     = !w_busy && cpu_read && !cpu_write && w_hit;

    // Outputs are forced quiet while reset is held
    assign cpu_busywait   = reset && (w_busy || (w_access_valid && !w_hit));
    assign cpu_readdata   = (reset && w_read_hit) ? w_byte : 8'h00;

    // Line state: cleared on reset, filled clean, dirtied by a write hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill_en) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_dirty[w_fill_idx] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set
    always_ff @(posedge clock) begin
        if (w_fill_en) begin
            r_tags[w_fill_idx] <= w_fill_tag;
            r_data[w_fill_idx] <= w_fill_data;
        end else if (w_write_hit) begin
            r_data[w_idx][{w_off, 3'b000} +: 8] <= cpu_writedata;
        end
    end

    dcache_ctrl u_ctrl (
        .clock         (clock),
        .reset         (reset),
        .access_valid  (w_access_valid),
        .hit           (w_hit),
        .victim_valid  (r_valid[w_idx]),
        .victim_dirty  (r_dirty[w_idx]),
        .victim_tag    (r_tags[w_idx]),
        .victim_data   (w_line),
        .cpu_tag       (w_tag),
        .cpu_idx       (w_idx),
        .mem_busywait  (mem_busywait),
        .mem_readdata  (mem_readdata),
        .busy          (w_busy),
        .fill_en       (w_fill_en),
        .fill_idx      (w_fill_idx),
        .fill_tag      (w_fill_tag),
        .fill_data     (w_fill_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache
// Description : Self-checking bench for dcache. A flat byte-array golden
//               memory plus a per-set tag model predict read data, stall
//               length and memory traffic for directed and random accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache;

    logic        clock;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [7:0]  cpu_writedata;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_tests = 0;
    int n_fail  = 0;

    dcache #(.NSETS(8), .BLOCK_BYTES(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    // A transfer occupies mem_lat cycles; back-to-back transfers need one
    // turnaround cycle, which makes a dirty miss cost 1+M extra cycles.
    logic [31:0] mem_arr [64];
    int          mem_lat = 5;
    int          mem_cnt;
    logic        mem_recover;
    logic        mem_loaded = 1'b0;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a + 1) * 17);
    endfunction

    assign mem_busywait = (mem_read || mem_write) && (mem_recover || (mem_cnt < mem_lat - 1));
    assign mem_readdata = mem_read ? mem_arr[mem_address] : 32'h0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++)
                mem_arr[i] <= {init_byte(4*i+3), init_byte(4*i+2), init_byte(4*i+1), init_byte(4*i)};
            mem_loaded <= 1'b1;
        end
        if (!reset || !(mem_read || mem_write)) begin
            mem_cnt     <= 0;
            mem_recover <= 1'b0;
        end else if (mem_recover) begin
            mem_recover <= 1'b0;
        end else if (mem_cnt >= mem_lat - 1) begin
            if (mem_write) mem_arr[mem_address] <= mem_writedata;
            mem_cnt     <= 0;
            mem_recover <= 1'b1;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] golden [256];
    bit         ref_valid [8];
    bit         ref_dirty [8];
    int         ref_tag   [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden_block(input int blk);
        return {golden[4*blk+3], golden[4*blk+2], golden[4*blk+1], golden[4*blk]};
    endfunction

    task automatic ref_clear();
        for (int s = 0; s < 8; s++) begin
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
            ref_tag[s]   = 0;
        end
    endtask

    // One CPU access: apply, count stall cycles, check traffic and result.
    task automatic access(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
        int  idx, tg, stall, exp_stall;
        bit  valid_acc, exp_hit, exp_wb, saw_wb, saw_rd, both;
        logic [7:0] exp_rd;
        idx       = int'(addr[4:2]);
        tg        = int'(addr[7:5]);
        valid_acc = rd ^ wr;
        exp_hit   = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_wb    = valid_acc && !exp_hit && ref_valid[idx] && ref_dirty[idx];
        if (!valid_acc || exp_hit) exp_stall = 0;
        else if (exp_wb)           exp_stall = 2 * mem_lat + 3;
        else                       exp_stall = mem_lat + 2;
        exp_rd = (rd && !wr) ? golden[addr] : 8'h00;

        @(posedge clock); #1;
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wd;
        stall = 0; saw_wb = 0; saw_rd = 0; both = 0;
        @(negedge clock);
        while (cpu_busywait === 1'b1 && stall < 200) begin
            if (mem_read && mem_write) both = 1;
            if (mem_write && !saw_wb) begin
                saw_wb = 1;
                check("wb_addr", {26'h0, mem_address}, {26'h0, 3'(ref_tag[idx]), 3'(idx)});
                check("wb_data", mem_writedata, golden_block(ref_tag[idx] * 8 + idx));
            end
            if (mem_read && !saw_rd) begin
                saw_rd = 1;
                check("fetch_addr", {26'h0, mem_address}, {26'h0, 3'(tg), 3'(idx)});
            end
            stall++;
            @(negedge clock);
        end
        check("stall", stall, exp_stall);
        check("wb_seen", {31'h0, saw_wb}, {31'h0, exp_wb});
        check("fetch_seen", {31'h0, saw_rd}, {31'h0, valid_acc && !exp_hit});
        check("strobe_excl", {31'h0, both}, 32'h0);
        check("idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rdata", {24'h0, cpu_readdata}, {24'h0, exp_rd});

        if (valid_acc) begin
            if (!exp_hit) begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
                ref_dirty[idx] = 1'b0;
            end
            if (wr) begin
                ref_dirty[idx] = 1'b1;
                golden[addr]   = wd;
            end
        end
    endtask

    initial begin
        int n;
        logic [31:0] w;
        logic [7:0]  a;
        for (int i = 0; i < 256; i++) golden[i] = init_byte(i);
        ref_clear();
        reset = 1'b0;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 8'h00; cpu_writedata = 8'h00;

        // Outputs quiet during reset even with a missing request present
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busywait", {31'h0, cpu_busywait}, 32'h0);
        check("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_addr", {26'h0, mem_address}, 32'h0);
        check("rst_mem_wdata", mem_writedata, 32'h0);
        check("rst_rdata", {24'h0, cpu_readdata}, 32'h0);
        cpu_read = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Directed sequence
        mem_lat = 5;
        access(1, 0, 8'h00, 8'h00);   // clean miss, 7 stall cycles, 0x11
        access(1, 0, 8'h01, 8'h00);   // hit, 0x22
        access(0, 1, 8'h02, 8'hAA);   // write hit
        access(1, 0, 8'h02, 8'h00);   // 0xAA
        access(1, 0, 8'h20, 8'h00);   // dirty miss: wb 0x44AA2211 to 0x00, fetch 0x08
        check("wb_result_word0", mem_arr[0], 32'h44AA2211);
        access(1, 1, 8'h40, 8'h55);   // ignored
        access(1, 1, 8'h21, 8'h55);   // ignored even on a hit
        access(1, 0, 8'h21, 8'h00);

        // Reset during FETCH aborts the miss
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 8'h01;
        n = 0;
        @(negedge clock);
        while (!mem_read && n < 50) begin n++; @(negedge clock); end
        check("rst_fetch_started", {31'h0, mem_read}, 32'h1);
        #2; reset = 1'b0; #1;
        check("abort_mem_read", {31'h0, mem_read}, 32'h0);
        check("abort_busywait", {31'h0, cpu_busywait}, 32'h0);
        check("abort_mem_addr", {26'h0, mem_address}, 32'h0);
        cpu_read = 1'b0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b1;
        ref_clear();
        for (int i = 0; i < 256; i++) begin
            w = mem_arr[i / 4];
            golden[i] = w[8 * (i % 4) +: 8];
        end
        access(1, 0, 8'h01, 8'h00);   // previously cached, must miss again

        // Random accesses over a few tags to mix hits, clean and dirty misses
        for (int k = 0; k < 300; k++) begin
            mem_lat = $urandom_range(1, 6);
            a = {3'($urandom_range(0, 3)), 5'($urandom)};
            n = $urandom_range(0, 9);
            if (n == 0)      access(1, 1, a, 8'($urandom));
            else if (n < 5)  access(0, 1, a, 8'($urandom));
            else             access(1, 0, a, 8'h00);
        end

        @(posedge clock); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the CPU's byte-wide load/store port and the 256x8 data memory that transfers 4-byte blocks. Read and write hits complete in zero stall cycles. Misses stall the CPU through `cpu_busywait` while the block is written back if dirty, then fetched over the memory's read/write/busywait handshake.

## Interface
- `NSETS`, 8: number of cache lines (index width = log2(NSETS) = 3).
- `BLOCK_BYTES`, 4: bytes per line; fixed to the memory block size.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `cpu_read`  in  1  load request, held until `cpu_busywait` is low.
- `cpu_write`  in  1  store request, held until `cpu_busywait` is low.
- `cpu_address`  in  8  byte address: tag[7:5], index[4:2], offset[1:0].
- `cpu_writedata`  in  8  store byte.
- `cpu_readdata`  out  8  load byte; valid while read-hit.
- `cpu_busywait`  out  1  CPU stall.
- `mem_read`  out  1  block fetch request.
- `mem_write`  out  1  block write-back request.
- `mem_address`  out  6  block address {tag,index}.
- `mem_writedata`  out  32  write-back block, byte 0 in [7:0].
- `mem_readdata`  in  32  fetched block, byte 0 in [7:0].
- `mem_busywait`  in  1  memory busy; raised in the same cycle as `mem_read`/`mem_write`, lowered when the transfer completes.

## Operation
- Per line: valid bit, dirty bit, 3-bit tag, 32-bit data. `hit = valid[idx] && tag[idx]==cpu_address[7:5]`.
- An access is valid when exactly one of `cpu_read`/`cpu_write` is 1. Both high is ignored: no stall and no state change.
- Read hit: `cpu_readdata` = byte `offset` of line `idx`, combinational; `cpu_busywait`=0.
- Write hit: byte written and dirty set at the next rising edge; `cpu_busywait`=0.
- Miss: `cpu_busywait`=1 combinationally, then the FSM runs.
- FSM states and transitions:
  - IDLE: on a valid access with a miss, go to WRITEBACK if the victim is valid and dirty, otherwise go to FETCH.
  - WRITEBACK: `mem_write`=1, `mem_address`={victim tag, idx}, `mem_writedata`=victim data. Go to FETCH on the edge where `mem_busywait`=0.
  - FETCH: `mem_read`=1, `mem_address`={cpu tag, idx}. Go to UPDATE on the edge where `mem_busywait`=0, capturing `mem_readdata`.
  - UPDATE: write the captured block, set the tag, valid=1, dirty=0; all `mem_*` strobes low. Go to IDLE.
- Back in IDLE, the held request now hits and is serviced in that cycle. A write re-sets dirty.
- `cpu_busywait`=1 in every non-IDLE state.
- If the CPU request drops mid-miss, the fill still completes.
- `cpu_readdata`=0 when there is no read hit. `mem_address`/`mem_writedata` are 0 when no strobe is asserted.

## Timing
- Reset (async, low): all valid/dirty=0, state=IDLE.
- Output values during reset: `cpu_busywait`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `cpu_readdata`=0.
- Reset asserted mid-miss aborts the transfer. Memory contents touched by a partial write-back are undefined.
- Hit latency: 0 stall cycles.
- Clean miss, memory busy for M cycles: stall = 1 (IDLE→FETCH) + M + 1 (UPDATE) cycles.
- Dirty miss: add 1 + M cycles for WRITEBACK.
- Strobes are registered from state, so they are glitch-free.
- `mem_read` and `mem_write` are never high together.
- `mem_busywait` is sampled only in WRITEBACK and FETCH. It is ignored in the first cycle of a state only if the memory has not yet raised it; the memory contract forbids this.

## Structure
- Shared package `cache_pkg` holds:
  - FSM state encoding (IDLE, WRITEBACK, FETCH, UPDATE);
  - field widths TAG_W=3, IDX_W=3, OFF_W=2, BLOCK_W=32;
  - the address-slicing constants.
- One sub-module, `dcache_ctrl`: FSM plus strobe/address muxing. The top holds the tag, valid, dirty and data arrays and the hit logic.

## Test plan
- Reset, then read 0x00 with memory word 0 = 0x44332211 and M=5 → busy 7 cycles, `mem_read` with `mem_address`=0x00, then `cpu_readdata`=0x11.
- Read 0x01 immediately after → hit, no stall, `cpu_readdata`=0x22.
- Write 0xAA to 0x02 (hit) → no stall, dirty[0]=1, no `mem_*` activity. A following read of 0x02 → 0xAA.
- Read 0x20 (same index, tag 1) → WRITEBACK with `mem_address`=0x00 and `mem_writedata`=0x44AA2211, then FETCH with `mem_address`=0x08. Total stall 13 cycles at M=5.
- `cpu_read`=`cpu_write`=1 at any address → `cpu_busywait`=0, no state change.
- Assert reset during FETCH → strobes drop immediately. A re-read of the previously cached 0x01 misses.
